// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset core.
// Holds the FSM states, the ALU operations and the opcode/funct values.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_RWB,
        S_ADDI,
        S_IWB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic funct_valid(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_NOR) || (fn == FN_SLT);
    endfunction

    function automatic alu_op_t funct_alu_op(input logic [5:0] fn);
        alu_op_t op;
        case (fn)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_NOR:  op = ALU_NOR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_core_alu.sv
// Combinational ALU for the multicycle core; zero flag feeds the beq decision.
module mc_alu
    import multicycle_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] y,
    output logic              zero
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_NOR: y = ~(a | b);
            ALU_SLT: y = DATA_W'($signed(a) < $signed(b));
            default: y = '0;
        endcase
        zero = (y == '0);
    end

endmodule

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset CPU: control FSM, register file and PC logic around mc_alu,
// talking to a single-port word-addressed memory through a req/ready handshake.
module multicycle_core
    import multicycle_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int NREGS    = 32,
    parameter int PC_START = 100,
    parameter int PC_END   = 114
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q, a_q, b_q, mdr_q, alu_out_q;
    logic              illegal_q;

    logic [5:0]        op, funct;
    logic [RIDX_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0] imm, pc_ext;
    logic              fetch_ok, req_c;

    logic [DATA_W-1:0] alu_a, alu_b, alu_y;
    alu_op_t           alu_op;
    logic              alu_zero;

    logic              rf_we;
    logic [RIDX_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rd [NREGS];

    assign op       = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs       = ir_q[21 +: RIDX_W];
    assign rt       = ir_q[16 +: RIDX_W];
    assign rd       = ir_q[11 +: RIDX_W];
    assign imm      = DATA_W'($signed(ir_q[15:0]));
    assign pc_ext   = DATA_W'(pc_q);
    assign fetch_ok = (int'(pc_q) <= PC_END);

    // Entry 0 is a hard zero, so r0 reads 0 and writes to it simply vanish.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf_rd[gi] = '0;
            end else begin : g_reg
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)
                        r_q <= '0;
                    else if (rf_we && rf_waddr == RIDX_W'(gi))
                        r_q <= rf_wdata;
                end
                assign rf_rd[gi] = r_q;
            end
        end
    endgenerate

    mc_alu #(.DATA_W(DATA_W)) u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .op   (alu_op),
        .y    (alu_y),
        .zero (alu_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        req_c    = 1'b0;
        mem_we   = 1'b0;
        mem_addr = alu_out_q[ADDR_W-1:0];
        alu_a    = a_q;
        alu_b    = b_q;
        alu_op   = ALU_ADD;
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_out_q;
        case (state_q)
            S_FETCH: begin
                mem_addr = pc_q;
                if (fetch_ok) begin
                    req_c = 1'b1;
                    if (mem_ready) state_d = S_DECODE;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                alu_a = pc_ext;
                alu_b = imm;
                case (op)
                    OP_RTYPE:     state_d = funct_valid(funct) ? S_EXEC : S_HALT;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_b   = imm;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                req_c = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr_q;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                req_c  = 1'b1;
                mem_we = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_op  = funct_alu_op(funct);
                state_d = S_RWB;
            end
            S_RWB: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                state_d  = S_FETCH;
            end
            S_ADDI: begin
                alu_b   = imm;
                state_d = S_IWB;
            end
            S_IWB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_op  = ALU_SUB;
                state_d = S_FETCH;
            end
            S_JUMP:  state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Datapath registers; only the state that owns a register may change it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= ADDR_W'(PC_START);
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mdr_q     <= '0;
            alu_out_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (fetch_ok && mem_ready) begin
                        ir_q <= mem_rdata;
                        pc_q <= pc_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    a_q       <= rf_rd[rs];
                    b_q       <= rf_rd[rt];
                    alu_out_q <= alu_y;
                    if (state_d == S_HALT) illegal_q <= 1'b1;
                end
                S_MEMADR, S_EXEC, S_ADDI: alu_out_q <= alu_y;
                S_MEMRD:  if (mem_ready) mdr_q <= mem_rdata;
                S_BRANCH: if (alu_zero) pc_q <= alu_out_q[ADDR_W-1:0];
                S_JUMP:   pc_q <= ir_q[ADDR_W-1:0];
                default:  ;
            endcase
        end
    end

    // Async reset must drop an in-flight request immediately, even though FETCH is the reset state.
    assign mem_req   = req_c & ~reset;
    assign mem_wdata = b_q;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: memory model with programmable wait states, directed
// programs and random programs checked against an instruction-level reference model.
module tb_multicycle_core;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int PCS = 100;
    localparam int PCE = 114;
    localparam logic [31:0] NOP = 32'h0000_0020;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_req, mem_we, halted, illegal;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr, pc_dbg;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    multicycle_core #(.DATA_W(DW), .ADDR_W(AW), .NREGS(32), .PC_START(PCS), .PC_END(PCE)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halted(halted), .illegal(illegal), .pc_dbg(pc_dbg)
    );

    // Second build with 8 registers on an always-ready memory.
    logic          rst8 = 1'b1;
    logic          req8, we8, halted8, ill8;
    logic [AW-1:0] addr8, pc8;
    logic [DW-1:0] wdata8, rdata8;
    logic [31:0]   mem8 [256];
    logic [31:0]   w8_data_q[$];

    assign rdata8 = mem8[addr8];

    multicycle_core #(.DATA_W(DW), .ADDR_W(AW), .NREGS(8), .PC_START(PCS), .PC_END(PCE)) dut8 (
        .clk(clk), .reset(rst8), .mem_req(req8), .mem_we(we8), .mem_addr(addr8),
        .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ready(1'b1),
        .halted(halted8), .illegal(ill8), .pc_dbg(pc8)
    );

    always @(negedge clk) if (req8 && we8) w8_data_q.push_back(wdata8);

    // Memory model for the main DUT.
    logic [31:0]   mem [256];
    int            wait_n = 0, wcnt = 0, pe_cnt = 0, rel_pe = 0, stab_err = 0, cyc = 0;
    logic          in_wait = 1'b0, sv_we = 1'b0;
    logic [AW-1:0] sv_addr = '0;
    logic [DW-1:0] sv_wdata = '0;
    int            wr_addr_q[$], wr_cyc_q[$];
    logic [31:0]   wr_data_q[$];

    always @(posedge clk) pe_cnt <= pe_cnt + 1;

    always @(negedge clk) begin
        if (mem_req && in_wait &&
            (mem_addr !== sv_addr || mem_we !== sv_we || mem_wdata !== sv_wdata))
            stab_err++;
        if (mem_req && wcnt >= wait_n) begin
            mem_ready = 1'b1;
            wcnt      = 0;
            in_wait   = 1'b0;
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                wr_addr_q.push_back(int'(mem_addr));
                wr_data_q.push_back(mem_wdata);
                wr_cyc_q.push_back(pe_cnt - rel_pe + 1);
            end else begin
                mem_rdata = mem[mem_addr];
            end
        end else begin
            mem_rdata = $urandom();
            if (mem_req) begin
                mem_ready = 1'b0;
                wcnt++;
                in_wait  = 1'b1;
                sv_addr  = mem_addr;
                sv_we    = mem_we;
                sv_wdata = mem_wdata;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                wcnt      = 0;
                in_wait   = 1'b0;
            end
        end
    end

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {6'h02, 26'(target)};
    endfunction

    // Instruction-level reference: executes the program and tallies cycles from the timing table.
    logic [31:0] mm [256];
    int          exp_wa[$], exp_wc[$];
    logic [31:0] exp_wd[$];
    int          exp_cycles, exp_ill;
    logic [31:0] exp_pc;

    task automatic model_run(input int w);
        logic [31:0] r [32];
        logic [31:0] pc, ins, imm, va, vb, res, addr;
        logic [5:0]  op, fn;
        int          rs, rt, rd, c, steps;
        logic        ok;
        for (int i = 0; i < 32; i++) r[i] = '0;
        exp_wa.delete(); exp_wd.delete(); exp_wc.delete();
        exp_ill = 0; pc = PCS; c = 0; steps = 0;
        while (steps < 300) begin
            steps++;
            if (pc > PCE) begin c += 1; break; end
            ins = mm[pc]; pc = (pc + 1) & 32'hFF;
            op = ins[31:26]; fn = ins[5:0];
            rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
            imm = {{16{ins[15]}}, ins[15:0]};
            va = r[rs]; vb = r[rt];
            if (op == 6'h00) begin
                ok = 1'b1; res = '0;
                case (fn)
                    6'h20: res = va + vb;
                    6'h22: res = va - vb;
                    6'h24: res = va & vb;
                    6'h25: res = va | vb;
                    6'h27: res = ~(va | vb);
                    6'h2A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
                    default: ok = 1'b0;
                endcase
                if (!ok) begin c += 2 + w; exp_ill = 1; break; end
                if (rd != 0) r[rd] = res;
                c += 4 + w;
            end else if (op == 6'h23) begin
                addr = (va + imm) & 32'hFF;
                if (rt != 0) r[rt] = mm[addr];
                c += 5 + 2 * w;
            end else if (op == 6'h2B) begin
                addr = (va + imm) & 32'hFF;
                mm[addr] = vb;
                c += 4 + 2 * w;
                exp_wa.push_back(int'(addr)); exp_wd.push_back(vb); exp_wc.push_back(c);
            end else if (op == 6'h04) begin
                if (va == vb) pc = (pc + imm) & 32'hFF;
                c += 3 + w;
            end else if (op == 6'h08) begin
                if (rt != 0) r[rt] = va + imm;
                c += 4 + w;
            end else if (op == 6'h02) begin
                pc = {24'd0, ins[7:0]};
                c += 3 + w;
            end else begin
                c += 2 + w; exp_ill = 1; break;
            end
        end
        exp_pc = pc; exp_cycles = c;
    endtask

    task automatic clear_prog();
        for (int a = 0; a < 256; a++) mem[a] = (a >= PCS && a <= PCE) ? NOP : $urandom();
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1 cyc++; end
    endtask

    task automatic start(input int w);
        reset = 1'b1; wait_n = w; stab_err = 0;
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b0;
        rel_pe = pe_cnt; cyc = 0;
    endtask

    task automatic prep(input int w);
        mm = mem;
        model_run(w);
        start(w);
    endtask

    task automatic finish(input string tag);
        while (!halted && cyc < 3000) step(1);
        $display("prog %s: cycles %0d halted %0b illegal %0b writes %0d", tag, cyc, halted, illegal, wr_data_q.size());
        chk({tag, "_halted"}, 32'(halted), 32'd1);
        chk({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
        chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
        chk({tag, "_pc"}, 32'(pc_dbg), exp_pc);
        chk({tag, "_nwr"}, 32'(wr_data_q.size()), 32'(exp_wd.size()));
        chk({tag, "_stable"}, 32'(stab_err), 32'd0);
        for (int i = 0; i < exp_wd.size() && i < wr_data_q.size(); i++) begin
            chk($sformatf("%s_wa%0d", tag, i), 32'(wr_addr_q[i]), 32'(exp_wa[i]));
            chk($sformatf("%s_wd%0d", tag, i), wr_data_q[i], exp_wd[i]);
            chk($sformatf("%s_wc%0d", tag, i), 32'(wr_cyc_q[i]), 32'(exp_wc[i]));
        end
    endtask

    task automatic gen_rand();
        logic [5:0] fns [6];
        int k;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        for (int a = 0; a < 256; a++) mem[a] = $urandom();
        for (int pc = PCS; pc <= 108; pc++) begin
            k = $urandom_range(0, 11);
            if (k < 6)
                mem[pc] = enc_r(fns[k], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            else if (k == 6)
                mem[pc] = enc_i(6'h23, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 127) - 64);
            else if (k == 7)
                mem[pc] = enc_i(6'h2B, $urandom_range(0, 7), 0, $urandom_range(0, 63));
            else if (k == 8)
                mem[pc] = enc_i(6'h04, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
            else if (k == 9)
                mem[pc] = enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
            else if (k == 10)
                mem[pc] = enc_j(pc + 1 + $urandom_range(0, 4));
            else if ($urandom_range(0, 3) == 0)
                mem[pc] = ($urandom_range(0, 1) == 1) ? 32'hFC00_0000 : enc_r(6'h21, 1, 2, 3);
            else
                mem[pc] = enc_r(6'h20, $urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        end
        for (int i = 1; i <= 6; i++) mem[108 + i] = enc_i(6'h2B, i, 0, 64 + i);
    endtask

    initial begin
        int reqs;

        // Reset state and first fetch.
        clear_prog();
        for (int a = 0; a < 256; a++) mem8[a] = NOP;
        mem8[100] = enc_i(6'h08, 9, 0, 7);
        mem8[101] = enc_i(6'h2B, 1, 0, 5);
        mem8[102] = enc_r(6'h20, 10, 1, 1);
        mem8[103] = enc_i(6'h2B, 2, 0, 6);
        mem8[104] = enc_j(200);
        @(posedge clk); @(posedge clk); #2;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_pc", 32'(pc_dbg), 32'd100);
        rst8 = 1'b0;
        mm = mem; model_run(0);
        reset = 1'b0; rel_pe = pe_cnt; cyc = 0; wait_n = 0;
        #1;
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", 32'(mem_addr), 32'd100);
        step(1);
        chk("first_pc", 32'(pc_dbg), 32'd101);
        finish("nops");

        // Load and add.
        clear_prog();
        mem[0] = 32'd7; mem[1] = 32'd5;
        mem[100] = enc_i(6'h23, 1, 0, 0);
        mem[101] = enc_i(6'h23, 2, 0, 1);
        mem[102] = enc_r(6'h20, 3, 1, 2);
        mem[103] = enc_i(6'h2B, 3, 0, 2);
        prep(0);
        finish("ldadd");
        chk("ldadd_addr", (wr_addr_q.size() > 0) ? 32'(wr_addr_q[0]) : 32'hFFFF_FFFF, 32'd2);
        chk("ldadd_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hFFFF_FFFF, 32'd12);
        chk("ldadd_cyc", (wr_cyc_q.size() > 0) ? 32'(wr_cyc_q[0]) : 32'hFFFF_FFFF, 32'd18);

        // Taken branch.
        clear_prog();
        mem[100] = enc_i(6'h04, 1, 1, 3);
        prep(0);
        step(3);
        chk("beq_taken_addr", 32'(mem_addr), 32'd104);
        finish("beq_t");

        // Not-taken branch and signed slt.
        clear_prog();
        mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd1;
        mem[100] = enc_i(6'h23, 1, 0, 0);
        mem[101] = enc_i(6'h23, 2, 0, 1);
        mem[102] = enc_i(6'h04, 2, 1, 3);
        mem[103] = enc_r(6'h2A, 3, 1, 2);
        mem[104] = enc_i(6'h2B, 3, 0, 2);
        prep(0);
        step(13);
        chk("beq_nt_addr", 32'(mem_addr), 32'd103);
        finish("beq_nt");
        chk("slt_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hFFFF_FFFF, 32'd1);

        // Jump, then run past the end and stay quiet.
        clear_prog();
        mem[100] = enc_j(110);
        prep(0);
        step(3);
        chk("j_addr", 32'(mem_addr), 32'd110);
        finish("jump");
        reqs = 0;
        repeat (5) begin step(1); reqs += int'(mem_req); end
        chk("halt_noreq", 32'(reqs), 32'd0);
        chk("halt_illegal", 32'(illegal), 32'd0);

        // Three wait states on every access.
        clear_prog();
        mem[100] = enc_i(6'h23, 1, 0, 0);
        prep(3);
        step(11);
        chk("wait_lw_addr", 32'(mem_addr), 32'd101);
        chk("wait_lw_req", 32'(mem_req), 32'd1);
        finish("wait3");

        // Illegal opcode.
        clear_prog();
        mem[100] = 32'hFC00_0000;
        prep(0);
        finish("illop");
        chk("illop_flag", 32'(illegal), 32'd1);

        // Writes to r0 are dropped.
        clear_prog();
        mem[100] = enc_i(6'h08, 0, 0, 5);
        mem[101] = enc_i(6'h2B, 0, 0, 3);
        prep(1);
        finish("r0");
        chk("r0_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hFFFF_FFFF, 32'd0);

        // Async reset in the middle of a store's wait.
        clear_prog();
        mem[100] = enc_i(6'h2B, 0, 0, 3);
        start(10);
        step(15);
        #3 reset = 1'b1;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_pc", 32'(pc_dbg), 32'd100);
        chk("arst_nowrite", 32'(wr_data_q.size()), 32'd0);
        start(0);
        #1;
        chk("arst_refetch_addr", 32'(mem_addr), 32'd100);
        chk("arst_refetch_req", 32'(mem_req), 32'd1);

        // Random programs.
        for (int t = 0; t < 8; t++) begin
            gen_rand();
            prep($urandom_range(0, 2));
            finish($sformatf("rnd%0d", t));
        end

        // Narrow register file build.
        chk("n8_halted", 32'(halted8), 32'd1);
        chk("n8_illegal", 32'(ill8), 32'd0);
        chk("n8_nwr", 32'(w8_data_q.size()), 32'd2);
        chk("n8_wd0", (w8_data_q.size() > 0) ? w8_data_q[0] : 32'hFFFF_FFFF, 32'd7);
        chk("n8_wd1", (w8_data_q.size() > 1) ? w8_data_q[1] : 32'hFFFF_FFFF, 32'd14);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multicycle MIPS-subset core: integrated control FSM, register file, ALU and PC logic.
- External single-port word-addressed memory behind a req/ready handshake, tolerating variable memory latency.
- Adds jump, addi, illegal-opcode trap and a clean halt output.
- Top of the CPU hierarchy; the testbench wraps it with a memory model.

Parameters:
- DATA_W, 32, datapath and register width (>=16).
- ADDR_W, 8, word-address width of PC and memory bus.
- NREGS, 32, register count; power of two, <=32. Register index is instr field truncated to log2(NREGS) bits.
- PC_START, 100, PC value after reset.
- PC_END, 114, last legal fetch address; a fetch with PC > PC_END halts instead.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- mem_req  out  1  memory access request, held until accepted.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  read data, valid in the mem_ready cycle.
- mem_ready  in  1  access completes in the cycle where mem_req && mem_ready.
- halted  out  1  core stopped.
- illegal  out  1  halt cause was an unknown opcode or funct.
- pc_dbg  out  ADDR_W  current PC.

Behaviour:
- Reset (async):
  - PC=PC_START, state=FETCH, mem_req=0, mem_we=0, halted=0, illegal=0.
  - IR, A, B, MDR, ALUOut = 0; registers cleared.
  - Reset mid-access drops mem_req the same instant.
- Instruction fields:
  - op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
  - imm=[15:0] sign-extended to DATA_W.
  - jaddr=[ADDR_W-1:0].
- Register file: reads of r0 return 0; writes to r0 are ignored.
- ALU:
  - add, sub, and, or, nor, slt (signed compare).
  - All results truncated to DATA_W; no overflow trap.
- PC: word-addressed, increments by 1 and wraps modulo 2^ADDR_W.
- Opcodes:
  - R-type 0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- FSM states and transitions:
  - FETCH:
    - If PC > PC_END: go to HALT (illegal=0) without issuing a request.
    - Otherwise assert mem_req (read) at PC.
    - On ready: IR<=rdata, PC<=PC+1, go to DECODE.
    - Wait states hold all outputs stable.
  - DECODE:
    - A<=reg[rs], B<=reg[rt], ALUOut<=PC+imm (branch target).
    - Dispatch on op. Unknown op, or unknown funct for R-type: go to HALT with illegal=1.
  - MEMADR: ALUOut<=A+imm; go to MEMRD for lw, MEMWR for sw.
  - MEMRD: read request at ALUOut; on ready MDR<=rdata, go to MEMWB.
  - MEMWB: reg[rt]<=MDR; go to FETCH.
  - MEMWR: write request, addr=ALUOut, wdata=B; on ready go to FETCH.
  - EXEC: ALUOut<=A op B; go to RWB.
  - RWB: reg[rd]<=ALUOut; go to FETCH.
  - ADDI: ALUOut<=A+imm; go to IWB.
  - IWB: reg[rt]<=ALUOut; go to FETCH.
  - BRANCH: if A==B, PC<=ALUOut; go to FETCH.
  - JUMP: PC<=jaddr; go to FETCH.
  - HALT: terminal. halted=1, mem_req=0. Only reset exits.
- Memory address: only ADDR_W bits of ALUOut are used; upper bits are ignored.
- Cycle counts with zero-wait memory (mem_ready tied 1):
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each wait cycle adds one.
- mem_req is never deasserted before ready except by reset.
- mem_ready without mem_req is ignored.

Decomposition:
- Package multicycle_pkg holds:
  - state enum;
  - opcode and funct constants;
  - ALU-op enum.
- One sub-module, mc_alu: combinational, parametrised DATA_W, inputs a, b, op; outputs y, zero.
- Register file and FSM stay inline.

Test Plan:
- Reset with default parameters, mem_ready=1 -> first fetch mem_addr=100; pc_dbg=101 after the FETCH cycle; halted=0.
- Load and add:
  - Stimulus: lw r1,0(r0) with mem[0]=7; lw r2,1(r0) with mem[1]=5; add r3,r1,r2; then sw r3,2(r0).
  - Response: write at address 2 with data 12.
  - Total cycles 5+5+4+4 = 18.
- Branch and slt:
  - beq r1,r1,+3 at PC 100 -> next fetch at 104.
  - beq with r1!=r2 -> next fetch at 101.
  - slt with r1=-1, r2=1 -> rd=1.
- Jump and halt:
  - j 110 -> next fetch at 110.
  - Program runs past 114 -> halted=1, illegal=0, no further mem_req.
- Wait states: mem_ready low for 3 cycles on each access -> mem_req, mem_addr and mem_wdata stable throughout; lw takes 5+6 = 11 cycles.
- Illegal and reset:
  - Opcode 0x3F -> halted=1, illegal=1.
  - Async reset asserted mid-MEMWR wait -> mem_req=0 immediately; after release, fetch restarts at 100.
- Edge cases:
  - Write to r0 -> still reads 0.
  - NREGS=8 build -> register indices use 3 bits.
